// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-memory path.
// Holds the AHB-Lite transfer/response encodings, the responder FSM encoding,
// and small helpers used by the data-memory responder.
package msrv32_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } dmem_state_e;

    // NONSEQ and SEQ request a transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    // Byte-lane merge: lanes with mask=1 come from upd, the rest from base.
    function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] base,
                                                      input logic [WORD_W-1:0] upd,
                                                      input logic [MASK_W-1:0] mask);
        logic [WORD_W-1:0] res;
        res = base;
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (mask[b]) res[8*b +: 8] = upd[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/msrv32_dmem_ram.sv
// Word-addressed data RAM, 2**DEPTH_LOG2 x 32.
// Ports: clk, rst_n (sync active-low, clears only the read register),
//        rd_en/rd_addr -> rd_data (one-cycle synchronous read, old data on
//        read-during-write), wr_en/wr_addr/wr_data/wr_be (byte-lane write).
module msrv32_dmem_ram
    import msrv32_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WORD_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [MASK_W-1:0]     wr_be
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // Read register only changes on a read request.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    // Array is not reset; contents survive a core reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (wr_en && wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/msrv32_dmem_slave.sv
// AHB-Lite style data-memory responder for the msrv32 core data port.
// Ports: ms_riscv32_mp_clk_in, ms_riscv32_mp_rst_in (sync active-low);
//        address phase: dm_addr_in, dm_data_in, dm_wr_req_in, dm_wr_mask_in,
//        htrans_in; data phase: dm_rdata_out, hready_out, hresp_out.
// Out-of-range accesses get a two-cycle ERROR response and never touch RAM.
module msrv32_dmem_slave
    import msrv32_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [31:0]       dm_addr_in,
    input  logic [31:0]       dm_data_in,
    input  logic              dm_wr_req_in,
    input  logic [3:0]        dm_wr_mask_in,
    input  logic [1:0]        htrans_in,
    output logic [31:0]       dm_rdata_out,
    output logic              hready_out,
    output logic              hresp_out
);

    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [MASK_W-1:0]     mask_q, mask_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  hready_q, hready_d;
    logic                  hresp_q, hresp_d;
    logic [MASK_W-1:0]     fwd_mask_q, fwd_mask_d;
    logic [WORD_W-1:0]     fwd_data_q, fwd_data_d;

    logic [31:0]           offset_c;
    logic                  in_range_c;
    logic [DEPTH_LOG2-1:0] in_idx_c;
    logic                  accept_c;
    logic                  complete_c;
    logic                  ram_we_c;
    logic                  rd_fire_c;
    logic [DEPTH_LOG2-1:0] rd_addr_c;
    logic [WORD_W-1:0]     ram_rdata;

    // Range decode on the live address phase; low two address bits ignored.
    always_comb begin
        offset_c   = dm_addr_in - BASE_ADDR;
        in_range_c = (dm_addr_in >= BASE_ADDR) && ((offset_c >> (DEPTH_LOG2 + 2)) == 32'd0);
        in_idx_c   = DEPTH_LOG2'(offset_c >> 2);
    end

    // Next-state, capture, RAM control and next registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        hready_d   = 1'b1;
        hresp_d    = HRESP_OKAY;

        accept_c   = hready_q && htrans_active(htrans_in);
        complete_c = (state_q == ST_DATA) && (cnt_q == '0);
        // A reset edge drops any write that would have committed on it.
        ram_we_c   = ms_riscv32_mp_rst_in && complete_c && wr_q;

        // Zero-wait reads must hit the RAM on the accepting edge; with wait
        // states the read is deferred to the edge entering the final cycle
        // so dm_rdata_out only changes when the data phase completes.
        if (ZERO_WAIT) begin
            rd_fire_c = accept_c && in_range_c && !dm_wr_req_in;
            rd_addr_c = in_idx_c;
        end else begin
            rd_fire_c = (state_q == ST_DATA) && (cnt_q == CNT_W'(1)) && !wr_q;
            rd_addr_c = idx_q;
        end

        if (accept_c) begin
            idx_d   = in_idx_c;
            wr_d    = dm_wr_req_in;
            mask_d  = dm_wr_mask_in;
            wdata_d = dm_data_in;
        end

        // The RAM returns old data when a write to the same word commits on
        // the read edge; remember the written lanes to merge at the output.
        if (rd_fire_c) begin
            fwd_data_d = wdata_q;
            fwd_mask_d = (ram_we_c && (idx_q == rd_addr_c)) ? mask_q : '0;
        end

        case (state_q)
            ST_DATA: begin
                if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
                else             state_d = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            state_d = in_range_c ? ST_DATA : ST_ERR1;
            cnt_d   = in_range_c ? CNT_W'(WAIT_STATES) : '0;
        end

        case (state_d)
            ST_DATA: hready_d = (cnt_d == '0);
            ST_ERR1: begin
                hready_d = 1'b0;
                hresp_d  = HRESP_ERROR;
            end
            ST_ERR2: hresp_d = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            hready_q   <= 1'b1;
            hresp_q    <= HRESP_OKAY;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            hready_q   <= hready_d;
            hresp_q    <= hresp_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    msrv32_dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (ms_riscv32_mp_clk_in),
        .rst_n   (ms_riscv32_mp_rst_in),
        .rd_en   (rd_fire_c),
        .rd_addr (rd_addr_c),
        .rd_data (ram_rdata),
        .wr_en   (ram_we_c),
        .wr_addr (idx_q),
        .wr_data (wdata_q),
        .wr_be   (mask_q)
    );

    assign dm_rdata_out = merge_bytes(ram_rdata, fwd_data_q, fwd_mask_q);
    assign hready_out   = hready_q;
    assign hresp_out    = hresp_q;

endmodule

// File: tb/tb_msrv32_dmem_slave.sv
// Scoreboard bench: dut0 runs with zero wait states, dut1 with three.
module tb_msrv32_dmem_slave;

    typedef struct packed {
        logic        is_err;
        logic        is_wr;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n    [2];
    logic [31:0] addr_i   [2];
    logic [31:0] wdata_i  [2];
    logic        wr_i     [2];
    logic [3:0]  mask_i   [2];
    logic [1:0]  htrans_i [2];
    logic [31:0] rdata_o  [2];
    logic        hready_o [2];
    logic        hresp_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        cur     [2];
    bit          pend    [2];
    int          wcnt    [2];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    msrv32_dmem_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_dut0 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n[0]),
        .dm_addr_in           (addr_i[0]),
        .dm_data_in           (wdata_i[0]),
        .dm_wr_req_in         (wr_i[0]),
        .dm_wr_mask_in        (mask_i[0]),
        .htrans_in            (htrans_i[0]),
        .dm_rdata_out         (rdata_o[0]),
        .hready_out           (hready_o[0]),
        .hresp_out            (hresp_o[0])
    );

    msrv32_dmem_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_dut1 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n[1]),
        .dm_addr_in           (addr_i[1]),
        .dm_data_in           (wdata_i[1]),
        .dm_wr_req_in         (wr_i[1]),
        .dm_wr_mask_in        (mask_i[1]),
        .htrans_in            (htrans_i[1]),
        .dm_rdata_out         (rdata_o[1]),
        .hready_out           (hready_o[1]),
        .hresp_out            (hresp_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue an expectation, present the address phase, hold it until accepted.
    task automatic xfer(input int k, input logic [31:0] a, input logic [31:0] d, input logic wr,
                        input logic [3:0] m, input logic err, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        e.is_err = err;
        e.is_wr  = wr;
        e.rdata  = exp_rd;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        addr_i[k]   = a;
        wdata_i[k]  = d;
        wr_i[k]     = wr;
        mask_i[k]   = m;
        htrans_i[k] = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hready_o[k] && n < 30);
        if (!hready_o[k]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: hready %b required 1", k, hready_o[k]);
        end
        @(posedge clk);
        #1;
        htrans_i[k] = 2'b00;
        wr_i[k]     = 1'b0;
        mask_i[k]   = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: tracks each accepted address phase through its data phase.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                pend[k]    = 1'b0;
                last_rd[k] = 32'h0;
                if (k == 0) q0.delete();
                else        q1.delete();
            end else begin
                if (pend[k]) begin
                    if (cur[k].is_err) begin
                        if (wcnt[k] == 0) begin
                            check($sformatf("dut%0d err1_hready", k), 32'(hready_o[k]), 32'd0);
                            check($sformatf("dut%0d err1_hresp", k), 32'(hresp_o[k]), 32'd1);
                            wcnt[k] = 1;
                        end else begin
                            check($sformatf("dut%0d err2_hready", k), 32'(hready_o[k]), 32'd1);
                            check($sformatf("dut%0d err2_hresp", k), 32'(hresp_o[k]), 32'd1);
                            check($sformatf("dut%0d err_rdata_hold", k), rdata_o[k], last_rd[k]);
                            pend[k] = 1'b0;
                        end
                    end else if (!hready_o[k]) begin
                        wcnt[k]++;
                        if (wcnt[k] > 12) begin
                            check($sformatf("dut%0d data_phase_timeout", k), 32'(hready_o[k]), 32'd1);
                            pend[k] = 1'b0;
                        end
                    end else begin
                        check($sformatf("dut%0d wait_cycles", k), 32'(wcnt[k]), (k == 0) ? 32'd0 : 32'd3);
                        check($sformatf("dut%0d okay_hresp", k), 32'(hresp_o[k]), 32'd0);
                        if (!cur[k].is_wr) last_rd[k] = cur[k].rdata;
                        check($sformatf("dut%0d %s_rdata", k, cur[k].is_wr ? "wr_hold" : "rd"),
                              rdata_o[k], last_rd[k]);
                        pend[k] = 1'b0;
                    end
                end
                if (hready_o[k] && htrans_i[k][1]) begin
                    if (pend[k]) check($sformatf("dut%0d overlap_accept", k), 32'd1, 32'd0);
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check($sformatf("dut%0d unexpected_accept", k), 32'd1, 32'd0);
                        pend[k] = 1'b0;
                    end else begin
                        cur[k]  = (k == 0) ? q0.pop_front() : q1.pop_front();
                        pend[k] = 1'b1;
                        wcnt[k] = 0;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]    = 1'b0;
            addr_i[k]   = 32'h0;
            wdata_i[k]  = 32'h0;
            wr_i[k]     = 1'b0;
            mask_i[k]   = 4'h0;
            htrans_i[k] = 2'b00;
            pend[k]     = 1'b0;
            wcnt[k]     = 0;
            last_rd[k]  = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d reset_hready", k), 32'(hready_o[k]), 32'd1);
            check($sformatf("dut%0d reset_hresp", k), 32'(hresp_o[k]), 32'd0);
            check($sformatf("dut%0d reset_rdata", k), rdata_o[k], 32'h0);
        end
        @(posedge clk);
        #1;

        // dut0, zero wait states
        xfer(0, 32'h0001_0000, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 32'h0);
        xfer(0, 32'h0001_0000, 32'h0,         1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        xfer(0, 32'h0001_0000, 32'h0,         1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        xfer(0, 32'h0001_0004, 32'h1122_3344, 1'b1, 4'hF, 1'b0, 32'h0);
        idle(1);
        xfer(0, 32'h0001_0004, 32'h00AA_0000, 1'b1, 4'h4, 1'b0, 32'h0);
        idle(1);
        xfer(0, 32'h0001_0004, 32'h0,         1'b0, 4'h0, 1'b0, 32'h11AA_3344);
        xfer(0, 32'h0001_0008, 32'h1122_3344, 1'b1, 4'hF, 1'b0, 32'h0);
        idle(1);
        xfer(0, 32'h0001_0008, 32'h0000_00FF, 1'b1, 4'h1, 1'b0, 32'h0);
        xfer(0, 32'h0001_0008, 32'h0,         1'b0, 4'h0, 1'b0, 32'h1122_33FF);
        xfer(0, 32'h0001_0008, 32'h1234_5678, 1'b1, 4'h0, 1'b0, 32'h0);
        idle(1);
        xfer(0, 32'h0001_0008, 32'h0,         1'b0, 4'h0, 1'b0, 32'h1122_33FF);
        xfer(0, 32'h0001_0010, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0, 32'h0);
        xfer(0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, 32'h0);
        xfer(0, 32'h0001_1000, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, 32'h0);
        xfer(0, 32'h0000_FFFC, 32'h0,         1'b0, 4'h0, 1'b1, 32'h0);
        xfer(0, 32'h0001_0FFC, 32'hA5A5_A5A5, 1'b1, 4'hF, 1'b0, 32'h0);
        xfer(0, 32'h0001_0FFC, 32'h0,         1'b0, 4'h0, 1'b0, 32'hA5A5_A5A5);
        xfer(0, 32'h0001_0010, 32'h0,         1'b0, 4'h0, 1'b0, 32'hCAFE_F00D);
        xfer(0, 32'h0001_0000, 32'h0,         1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        xfer(0, 32'h0001_0004, 32'h0,         1'b0, 4'h0, 1'b0, 32'h11AA_3344);
        xfer(0, 32'h0001_0008, 32'h0,         1'b0, 4'h0, 1'b0, 32'h1122_33FF);
        xfer(0, 32'h0001_0012, 32'h0,         1'b0, 4'h0, 1'b0, 32'hCAFE_F00D);
        idle(2);

        // dut1, three wait states
        xfer(1, 32'h0001_0020, 32'h0BAD_F00D, 1'b1, 4'hF, 1'b0, 32'h0);
        xfer(1, 32'h0001_0020, 32'h0,         1'b0, 4'h0, 1'b0, 32'h0BAD_F00D);
        xfer(1, 32'h0001_0020, 32'h0000_00EE, 1'b1, 4'h1, 1'b0, 32'h0);
        xfer(1, 32'h0001_0020, 32'h0,         1'b0, 4'h0, 1'b0, 32'h0BAD_F0EE);
        xfer(1, 32'h0000_0000, 32'h0,         1'b0, 4'h0, 1'b1, 32'h0);
        idle(2);
        // reset lands mid data phase of a write that must be dropped
        xfer(1, 32'h0001_0020, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("dut1 midreset_hready", 32'(hready_o[1]), 32'd1);
        check("dut1 midreset_hresp", 32'(hresp_o[1]), 32'd0);
        check("dut1 midreset_rdata", rdata_o[1], 32'h0);
        @(posedge clk);
        #1;
        xfer(1, 32'h0001_0020, 32'h0,         1'b0, 4'h0, 1'b0, 32'h0BAD_F0EE);

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pend[0] || pend[1]) && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d/%0d required 0/0", q0.size() + int'(pend[0]),
                     q1.size() + int'(pend[1]));
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
